// File: rtl/send_ctl_pkg.sv
// Shared SEND controller constants: FSM state encodings, receive window base, port field width.
// No logic; no latency or backpressure of its own.
// Imported by send_ctl and rr_arb.
package send_ctl_pkg;

    typedef enum logic [1:0] {
        SC_IDLE  = 2'd0,
        SC_XFER  = 2'd1,
        SC_DRAIN = 2'd2,
        SC_DONE  = 2'd3
    } sc_state_t;

    localparam int         PORTW       = 4;
    localparam logic [7:0] SEND_RXBASE = 8'hC0;

endpackage

// File: rtl/send_ctl_rr_arb.sv
// NPU-way round-robin arbiter: grant is combinational from req and the registered pointer.
// Zero latency; the pointer moves to grant+1 only when en is high and something was granted.
// Requesters that are not granted simply keep req asserted.
module rr_arb
    import send_ctl_pkg::*;
#(
    parameter  int NPU = 4,
    localparam int IW  = $clog2(NPU)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NPU-1:0] req,
    input  logic           en,
    output logic [NPU-1:0] gnt,
    output logic [IW-1:0]  gnt_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic          hit;

    // Scan from the pointer upwards; NPU is a power of two so the index wraps for free.
    always_comb begin
        hit     = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        idx     = '0;
        for (int i = 0; i < NPU; i++) begin
            idx = ptr + IW'(i);
            if (!hit && req[idx]) begin
                hit     = 1'b1;
                gnt_idx = idx;
            end
        end
        if (hit && en) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && hit) begin
            ptr <= gnt_idx + IW'(1);
        end
    end

endmodule

// File: rtl/send_ctl.sv
// SEND transfer controller: copies size words from the granted PU's dmem into the destination receive window.
// Latency: grant at t, reads t+1..t+N, writes t+2..t+N+1, done at t+N+2 (size 0 / bad port: done at t+1).
// Backpressure: only the granted PU stalls (req held until done); other requesters wait in the arbiter.
module send_ctl
    import send_ctl_pkg::*;
#(
    parameter  int            NPU    = 4,
    parameter  int            DW     = 16,
    parameter  int            AW     = 8,
    parameter  logic [AW-1:0] RXBASE = AW'(SEND_RXBASE),
    localparam int            IW     = $clog2(NPU)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPU-1:0]       req,
    input  logic [NPU*AW-1:0]    req_addr,
    input  logic [NPU*AW-1:0]    req_size,
    input  logic [NPU*PORTW-1:0] req_port,
    output logic [NPU-1:0]       done,
    output logic                 err,
    output logic                 rd_en,
    output logic [IW-1:0]        rd_pu,
    output logic [AW-1:0]        rd_addr,
    input  logic [DW-1:0]        rd_data,
    output logic                 wr_en,
    output logic [IW-1:0]        wr_pu,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data
);

    sc_state_t        state, state_n;
    logic [IW-1:0]    src;
    logic [AW-1:0]    base;
    logic [AW-1:0]    size;
    logic [PORTW-1:0] port;
    logic [AW-1:0]    cnt;

    logic [NPU-1:0]   gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             arb_en;

    logic [AW-1:0]    sel_addr;
    logic [AW-1:0]    sel_size;
    logic [PORTW-1:0] sel_port;
    logic             sel_bad;
    logic             port_bad;

    assign arb_en  = (state == SC_IDLE);
    assign gnt_any = |gnt;

    rr_arb #(.NPU(NPU)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign sel_addr = req_addr[gnt_idx*AW +: AW];
    assign sel_size = req_size[gnt_idx*AW +: AW];
    assign sel_port = req_port[gnt_idx*PORTW +: PORTW];
    assign sel_bad  = (int'(sel_port) >= NPU);
    assign port_bad = (int'(port) >= NPU);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SC_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // cnt is the read index; it keeps counting through DRAIN so cnt-1 still addresses the last write.
    always_ff @(posedge clk) begin
        if (rst) begin
            src  <= '0;
            base <= '0;
            size <= '0;
            port <= '0;
            cnt  <= '0;
        end else if (state == SC_IDLE && gnt_any) begin
            src  <= gnt_idx;
            base <= sel_addr;
            size <= sel_size;
            port <= sel_port;
            cnt  <= '0;
        end else if (state == SC_XFER || state == SC_DRAIN) begin
            cnt  <= cnt + AW'(1);
        end
    end

    always_comb begin
        state_n = state;
        rd_en   = 1'b0;
        rd_pu   = '0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_pu   = '0;
        wr_addr = '0;
        wr_data = '0;
        done    = '0;
        err     = 1'b0;
        case (state)
            SC_IDLE: begin
                if (gnt_any) begin
                    state_n = (sel_size == '0 || sel_bad) ? SC_DONE : SC_XFER;
                end
            end
            SC_XFER: begin
                rd_en   = 1'b1;
                rd_pu   = src;
                rd_addr = base + cnt;
                if (cnt != '0) begin
                    wr_en   = 1'b1;
                    wr_pu   = port[IW-1:0];
                    wr_addr = RXBASE + cnt - AW'(1);
                    wr_data = rd_data;
                end
                if (cnt == size - AW'(1)) begin
                    state_n = SC_DRAIN;
                end
            end
            SC_DRAIN: begin
                wr_en   = 1'b1;
                wr_pu   = port[IW-1:0];
                wr_addr = RXBASE + cnt - AW'(1);
                wr_data = rd_data;
                state_n = SC_DONE;
            end
            SC_DONE: begin
                done[src] = 1'b1;
                err       = port_bad;
                state_n   = SC_IDLE;
            end
            default: state_n = SC_IDLE;
        endcase
    end

endmodule

// File: tb/tb_send_ctl.sv
// Directed plus randomized bench for send_ctl with dmem and copy/arbitration reference model.
module tb_send_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_addr;
    logic [31:0] req_size;
    logic [15:0] req_port;
    logic [3:0]  done;
    logic        err;
    logic        rd_en;
    logic [1:0]  rd_pu;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        wr_en;
    logic [1:0]  wr_pu;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;

    int checks   = 0;
    int failures = 0;
    int ptr_m    = 0;

    logic        mem_init;
    logic [31:0] seed;
    logic [15:0] mem     [4][256];
    logic [15:0] exp_mem [4][256];

    send_ctl dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_size (req_size),
        .req_port (req_port),
        .done     (done),
        .err      (err),
        .rd_en    (rd_en),
        .rd_pu    (rd_pu),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_pu    (wr_pu),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fill(input int p, input int a);
        logic [31:0] h;
        h = seed ^ (32'(p) << 8) ^ 32'(a);
        h = h * 32'h9E3779B1;
        return h[31:16];
    endfunction

    // Data memories of all PUs: one-cycle read latency, write on the edge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int p = 0; p < 4; p++)
                for (int a = 0; a < 256; a++)
                    mem[p][a] <= fill(p, a);
        end else if (wr_en) begin
            mem[wr_pu][wr_addr] <= wr_data;
        end
        if (rd_en) rd_data <= mem[rd_pu][rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_copy(input int s, input logic [7:0] a, input logic [7:0] n, input logic [3:0] p);
        logic [15:0] tmp [256];
        if (n == 8'd0 || p >= 4'd4) return;
        for (int k = 0; k < int'(n); k++) tmp[k] = exp_mem[s][8'(a + 8'(k))];
        for (int k = 0; k < int'(n); k++) exp_mem[p[1:0]][8'(8'hC0 + 8'(k))] = tmp[k];
    endtask

    task automatic mem_cmp(input string tag);
        int mism = 0;
        for (int p = 0; p < 4; p++)
            for (int a = 0; a < 256; a++)
                if (mem[p][a] !== exp_mem[p][a]) mism++;
        chk(tag, mism, 0);
    endtask

    function automatic int first_from(input int ptr, input logic [3:0] pend);
        for (int i = 0; i < 4; i++)
            if (pend[(ptr + i) % 4]) return (ptr + i) % 4;
        return -1;
    endfunction

    // Single requester on an idle controller: the grant lands on the first edge after req rises.
    task automatic xfer(input int s, input logic [7:0] a, input logic [7:0] n,
                        input logic [3:0] p, input int alt);
        int rc = 0, wc = 0, dc = 0;
        logic [3:0] dv = '0;
        logic ev = 1'b0;
        bit valid;
        valid = (n != 8'd0) && (p < 4'd4);
        model_copy(s, a, n, p);
        req_addr[s*8 +: 8] = a;
        req_size[s*8 +: 8] = n;
        req_port[s*4 +: 4] = p;
        req[s] = 1'b1;
        for (int c = 1; c <= 400 && dc == 0; c++) begin
            @(negedge clk);
            if (c == 2 && alt >= 0) req_size[s*8 +: 8] = 8'(alt);
            if (rd_en) begin
                chk("rd_slot", c, rc + 1);
                chk("rd_addr", rd_addr, 32'(8'(a + 8'(rc))));
                chk("rd_pu", rd_pu, s);
                rc++;
            end
            if (wr_en) begin
                chk("wr_slot", c, wc + 2);
                chk("wr_addr", wr_addr, 32'(8'(8'hC0 + 8'(wc))));
                chk("wr_pu", wr_pu, 32'(p[1:0]));
                wc++;
            end
            if (done != 4'd0) begin
                dc = c;
                dv = done;
                ev = err;
            end
        end
        req[s] = 1'b0;
        chk("done_cycle", dc, valid ? int'(n) + 2 : 1);
        chk("done_vec", dv, 32'(1) << s);
        chk("err", ev, p >= 4'd4);
        chk("rd_count", rc, valid ? int'(n) : 0);
        chk("wr_count", wc, valid ? int'(n) : 0);
        ptr_m = (s + 1) % 4;
        @(negedge clk);
    endtask

    task automatic arb_round(input logic [3:0] mask, input bit rand_size);
        logic [3:0] pend;
        logic [7:0] a [4];
        logic [7:0] n [4];
        logic [3:0] pt [4];
        int w, ew, guard;
        for (int i = 0; i < 4; i++) begin
            a[i]  = 8'($urandom_range(0, 127));
            n[i]  = rand_size ? 8'($urandom_range(0, 20)) : 8'd1;
            pt[i] = 4'($urandom_range(0, 5));
            req_addr[i*8 +: 8] = a[i];
            req_size[i*8 +: 8] = n[i];
            req_port[i*4 +: 4] = pt[i];
        end
        req   = mask;
        pend  = mask;
        guard = 0;
        while (pend != 4'd0 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (done != 4'd0) begin
                w = 0;
                for (int i = 3; i >= 0; i--) if (done[i]) w = i;
                ew = first_from(ptr_m, pend);
                chk("arb_grant", w, ew);
                chk("arb_err", err, pt[ew] >= 4'd4);
                model_copy(ew, a[ew], n[ew], pt[ew]);
                req[w]  = 1'b0;
                pend[w] = 1'b0;
                ptr_m   = (ew + 1) % 4;
            end
        end
        chk("arb_pending", pend, 0);
        @(negedge clk);
    endtask

    initial begin
        int seen;
        seed     = $urandom;
        rst      = 1'b1;
        mem_init = 1'b1;
        req      = '0;
        req_addr = '0;
        req_size = '0;
        req_port = '0;
        for (int p = 0; p < 4; p++)
            for (int a = 0; a < 256; a++)
                exp_mem[p][a] = fill(p, a);
        @(negedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        chk("rst_ctl", {done, err, rd_en, rd_pu, rd_addr, wr_en, wr_pu}, 0);
        chk("rst_wr", {wr_addr, wr_data}, 0);
        rst = 1'b0;
        @(negedge clk);
        ptr_m = 0;

        arb_round(4'b1111, 1'b0);
        arb_round(4'b1001, 1'b0);
        mem_cmp("mem_arb");

        xfer(1, 8'h10, 8'd3, 4'd2, -1);
        mem_cmp("mem_basic");
        xfer(0, 8'h20, 8'd0, 4'd1, -1);
        xfer(3, 8'h40, 8'd2, 4'h9, -1);
        xfer(2, 8'hFE, 8'd4, 4'd1, -1);
        xfer(0, 8'h20, 8'd70, 4'd3, -1);
        xfer(1, 8'h50, 8'd5, 4'd0, 1);
        mem_cmp("mem_edges");

        // Abort a size-8 transfer on its second XFER cycle; only word 0 reaches memory.
        req_addr[2*8 +: 8] = 8'h30;
        req_size[2*8 +: 8] = 8'd8;
        req_port[2*4 +: 4] = 4'd1;
        req[2] = 1'b1;
        @(negedge clk);
        chk("abort_rd1", rd_en, 1);
        @(negedge clk);
        chk("abort_rw2", {rd_en, wr_en}, 2'b11);
        rst    = 1'b1;
        req[2] = 1'b0;
        @(negedge clk);
        chk("abort_ctl", {done, err, rd_en, rd_pu, rd_addr, wr_en, wr_pu}, 0);
        chk("abort_wr", {wr_addr, wr_data}, 0);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done != 4'd0 || rd_en || wr_en) seen++;
        end
        chk("abort_quiet", seen, 0);
        model_copy(2, 8'h30, 8'd1, 4'd1);
        ptr_m = 0;
        arb_round(4'b1001, 1'b0);
        mem_cmp("mem_abort");

        for (int r = 0; r < 6; r++)
            xfer($urandom_range(0, 3), 8'($urandom_range(0, 127)),
                 8'($urandom_range(0, 20)), 4'($urandom_range(0, 5)), -1);
        for (int r = 0; r < 4; r++)
            arb_round(4'($urandom_range(1, 15)), 1'b1);
        mem_cmp("mem_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
